// File: rtl/lock_in_demod_if.sv
// Bus bundle for lock_in_demod: sample/reference inputs and X/Y result outputs.
// Optional LIA_MAG_EN adds the lia_mag_o magnitude output.
interface lock_in_demod_if #(
  parameter int ADC_W = 14,
  parameter int REF_W = 14,
  parameter int OUT_W = 14
);
  logic                    en_i;
  logic signed [ADC_W-1:0] adc_i;
  logic signed [REF_W-1:0] ref_i_i;
  logic signed [REF_W-1:0] ref_q_i;
  logic [4:0]              int_len_i;
  logic signed [OUT_W-1:0] lia_x_o;
  logic signed [OUT_W-1:0] lia_y_o;
  logic                    lia_valid_o;
  logic                    lia_sat_o;
`ifdef LIA_MAG_EN
  logic [OUT_W-1:0]        lia_mag_o;

  modport master (output en_i, adc_i, ref_i_i, ref_q_i, int_len_i,
                  input  lia_x_o, lia_y_o, lia_valid_o, lia_sat_o, lia_mag_o);
  modport slave  (input  en_i, adc_i, ref_i_i, ref_q_i, int_len_i,
                  output lia_x_o, lia_y_o, lia_valid_o, lia_sat_o, lia_mag_o);
`else
  modport master (output en_i, adc_i, ref_i_i, ref_q_i, int_len_i,
                  input  lia_x_o, lia_y_o, lia_valid_o, lia_sat_o);
  modport slave  (input  en_i, adc_i, ref_i_i, ref_q_i, int_len_i,
                  output lia_x_o, lia_y_o, lia_valid_o, lia_sat_o);
`endif
endinterface

// File: rtl/lock_in_demod.sv
// Dual-phase lock-in demodulator: multiply, integrate over 2^N samples, dump scaled/saturated X/Y.
// Define LIA_MAG_EN to add the registered magnitude estimate lia_mag_o.
module lock_in_demod #(
  parameter int ADC_W    = 14,
  parameter int REF_W    = 14,
  parameter int OUT_W    = 14,
  parameter int MAX_LOG2 = 16
) (
  input  logic              dac_clk_i,
  input  logic              dac_rst_i,
  lock_in_demod_if.slave    bus
);
  localparam int PROD_W = ADC_W + REF_W;
  localparam int ACC_W  = PROD_W + MAX_LOG2;
  localparam int CNT_W  = MAX_LOG2 + 1;
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = -OUT_MAX - ACC_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DUMP} state_t;

  function automatic logic [4:0] clamp_n(input logic [4:0] n);
    if (int'(n) > MAX_LOG2) return 5'(MAX_LOG2);
    return n;
  endfunction

  // Bit OUT_W of the result flags saturation.
  function automatic logic [OUT_W:0] scale_sat(input logic signed [ACC_W-1:0] s,
                                                input logic [4:0] n);
    logic signed [ACC_W-1:0] sh;
    sh = s >>> (REF_W - 1 + int'(n));
    if (sh > OUT_MAX) return {1'b1, OUT_MAX[OUT_W-1:0]};
    if (sh < OUT_MIN) return {1'b1, OUT_MIN[OUT_W-1:0]};
    return {1'b0, sh[OUT_W-1:0]};
  endfunction

  state_t           state_q, state_d;
  logic [4:0]       n_act_q, n_act_d, n_cur;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_cur, mask;
  logic             last_d;

  always_comb begin
    state_d = state_q;
    n_act_d = n_act_q;
    cnt_d   = cnt_q;
    last_d  = 1'b0;
    n_cur   = (state_q == RUN) ? n_act_q : clamp_n(bus.int_len_i);
    cnt_cur = (state_q == RUN) ? cnt_q : '0;
    mask    = (CNT_W'(1) << n_cur) - CNT_W'(1);
    if (!bus.en_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      n_act_d = n_cur;
      last_d  = (cnt_cur == mask);
      if (last_d) begin
        state_d = DUMP;
        cnt_d   = '0;
      end else begin
        state_d = RUN;
        cnt_d   = cnt_cur + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state_q <= IDLE;
      n_act_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      n_act_q <= n_act_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stage p0: input capture, tagged with window-end flag and exponent.
  logic signed [ADC_W-1:0] adc_p0;
  logic signed [REF_W-1:0] ri_p0, rq_p0;
  logic                    vld_p0, last_p0;
  logic [4:0]              n_p0;

  always_ff @(posedge dac_clk_i) begin
    if (bus.en_i) begin
      adc_p0 <= bus.adc_i;
      ri_p0  <= bus.ref_i_i;
      rq_p0  <= bus.ref_q_i;
    end
    if (dac_rst_i) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      n_p0    <= '0;
    end else begin
      vld_p0  <= bus.en_i;
      last_p0 <= last_d;
      n_p0    <= n_cur;
    end
  end

  // Stage p1: products; a dropped enable discards anything in flight.
  logic signed [PROD_W-1:0] prod_i_p1, prod_q_p1;
  logic                     vld_p1, last_p1;
  logic [4:0]               n_p1;

  always_ff @(posedge dac_clk_i) begin
    prod_i_p1 <= adc_p0 * ri_p0;
    prod_q_p1 <= adc_p0 * rq_p0;
    if (dac_rst_i) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      n_p1    <= '0;
    end else begin
      vld_p1  <= vld_p0 & bus.en_i;
      last_p1 <= last_p0;
      n_p1    <= n_p0;
    end
  end

  // Stage p2: accumulate; the window's final product goes straight into the dump.
  logic signed [ACC_W-1:0] acc_i_p2, acc_q_p2, sum_i, sum_q;
  logic [OUT_W:0]          res_x, res_y;
  logic                    dump;
  logic signed [OUT_W-1:0] x_p2, y_p2;
  logic                    vld_p2, sat_p2;

  assign sum_i = acc_i_p2 + {{MAX_LOG2{prod_i_p1[PROD_W-1]}}, prod_i_p1};
  assign sum_q = acc_q_p2 + {{MAX_LOG2{prod_q_p1[PROD_W-1]}}, prod_q_p1};
  assign res_x = scale_sat(sum_i, n_p1);
  assign res_y = scale_sat(sum_q, n_p1);
  assign dump  = vld_p1 & last_p1 & bus.en_i;

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i || !bus.en_i) begin
      acc_i_p2 <= '0;
      acc_q_p2 <= '0;
    end else if (vld_p1) begin
      acc_i_p2 <= last_p1 ? '0 : sum_i;
      acc_q_p2 <= last_p1 ? '0 : sum_q;
    end
    if (dac_rst_i) begin
      x_p2   <= '0;
      y_p2   <= '0;
      sat_p2 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= dump;
      if (dump) begin
        x_p2   <= res_x[OUT_W-1:0];
        y_p2   <= res_y[OUT_W-1:0];
        sat_p2 <= res_x[OUT_W] | res_y[OUT_W];
      end
    end
  end

  assign bus.lia_x_o     = x_p2;
  assign bus.lia_y_o     = y_p2;
  assign bus.lia_valid_o = vld_p2;
  assign bus.lia_sat_o   = sat_p2;

`ifdef LIA_MAG_EN
  function automatic logic [OUT_W-1:0] mag_calc(input logic [OUT_W-1:0] x,
                                                input logic [OUT_W-1:0] y);
    logic [OUT_W:0]   ax, ay, mx, mn;
    logic [OUT_W+1:0] m;
    ax = x[OUT_W-1] ? ({1'b0, ~x} + (OUT_W+1)'(1)) : {1'b0, x};
    ay = y[OUT_W-1] ? ({1'b0, ~y} + (OUT_W+1)'(1)) : {1'b0, y};
    mx = (ax > ay) ? ax : ay;
    mn = (ax > ay) ? ay : ax;
    m  = {1'b0, mx} + {2'b00, mn[OUT_W:1]};
    if (m > (OUT_W+2)'({OUT_W{1'b1}})) return {OUT_W{1'b1}};
    return m[OUT_W-1:0];
  endfunction

  logic [OUT_W-1:0] mag_p2;

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) mag_p2 <= '0;
    else if (dump) mag_p2 <= mag_calc(res_x[OUT_W-1:0], res_y[OUT_W-1:0]);
  end

  assign bus.lia_mag_o = mag_p2;
`endif
endmodule
